// File: rtl/kp_voice_alloc_if.sv
// kp_voice_alloc_if -- event/voice bus of the Karplus-Strong voice allocator.
//
// Signals:
//   note_on, note_off  one-cycle event strobes
//   note_number        MIDI note (7 bits), sampled with either strobe
//   velocity           MIDI velocity (7 bits), sampled with note_on
//   voice_done         per-voice "delay line decayed to silence" level (4 bits)
//   trig               per-voice one-cycle pluck pulse (4 bits)
//   voice_release      per-voice one-cycle "switch to release decay" pulse (4 bits);
//                      carries the release output, renamed because 'release'
//                      is a reserved word in SystemVerilog
//   voice_note         4x7 packed note per voice, voice v at [7v+6:7v]
//   voice_vel          4x7 packed velocity per voice, same layout
//   voice_active       per-voice "not FREE" flag (4 bits)
//   note_dropped       one-cycle pulse, a note_on was discarded
//
// Modports: master = event source / engine side, slave = allocator.

interface kp_voice_alloc_if;
  logic        note_on;
  logic        note_off;
  logic [6:0]  note_number;
  logic [6:0]  velocity;
  logic [3:0]  voice_done;
  logic [3:0]  trig;
  logic [3:0]  voice_release;
  logic [27:0] voice_note;
  logic [27:0] voice_vel;
  logic [3:0]  voice_active;
  logic        note_dropped;

  modport master (
    output note_on, note_off, note_number, velocity, voice_done,
    input  trig, voice_release, voice_note, voice_vel, voice_active, note_dropped
  );

  modport slave (
    input  note_on, note_off, note_number, velocity, voice_done,
    output trig, voice_release, voice_note, voice_vel, voice_active, note_dropped
  );
endinterface

// File: rtl/kp_voice_alloc.sv
// kp_voice_alloc -- 4-voice note allocator for a Karplus-Strong string engine.
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous active-high reset
//   bus    kp_voice_alloc_if.slave: note events in, per-voice control out
//
// Each voice is FREE, HELD or RELEASING and carries a 2-bit age rank
// (0 = most recently allocated, 3 = oldest). All outputs are registered,
// so trig/voice_release/note_dropped appear one cycle after the strobe.
//
// Configuration macro KP_VOICE_STEAL_EN: when defined, a note_on arriving
// with every voice busy steals the oldest RELEASING voice (else the oldest
// HELD voice). When undefined, that note_on is discarded and note_dropped
// pulses.

module kp_voice_alloc (
  input  logic              clk,
  input  logic              reset,
  kp_voice_alloc_if.slave   bus
);

  typedef enum logic [1:0] {
    V_FREE      = 2'd0,
    V_HELD      = 2'd1,
    V_RELEASING = 2'd2
  } voice_state_t;

  voice_state_t state_q [4];
  voice_state_t state_d [4];
  logic [1:0]   rank_q  [4];
  logic [1:0]   rank_d  [4];
  logic [6:0]   note_q  [4];
  logic [6:0]   note_d  [4];
  logic [6:0]   vel_q   [4];
  logic [6:0]   vel_d   [4];
  logic [3:0]   trig_q, trig_d;
  logic [3:0]   rel_q, rel_d;
  logic         drop_q, drop_d;

  logic         ev_on, ev_off;
  logic         hit_found, free_found, off_found;
  logic [1:0]   hit_idx, free_idx, off_idx;
  logic         alloc_en;
  logic [1:0]   alloc_idx;
  logic [1:0]   old_rank;
  logic [27:0]  note_bus, vel_bus;

  // Event decode and voice searches. A velocity-0 note_on is a note_off;
  // a real note_off in the same cycle as any note_on is dropped.
  // Searches run from high to low index so the lowest match wins.
  always_comb begin
    ev_on      = bus.note_on && (bus.velocity != 7'd0);
    ev_off     = bus.note_on ? (bus.velocity == 7'd0) : bus.note_off;
    hit_found  = 1'b0;
    hit_idx    = 2'd0;
    free_found = 1'b0;
    free_idx   = 2'd0;
    off_found  = 1'b0;
    off_idx    = 2'd0;
    for (int v = 3; v >= 0; v--) begin
      if ((state_q[v] != V_FREE) && (note_q[v] == bus.note_number)) begin
        hit_found = 1'b1;
        hit_idx   = 2'(v);
      end
      if (state_q[v] == V_FREE) begin
        free_found = 1'b1;
        free_idx   = 2'(v);
      end
      if ((state_q[v] == V_HELD) && (note_q[v] == bus.note_number)) begin
        off_found = 1'b1;
        off_idx   = 2'(v);
      end
    end
  end

`ifdef KP_VOICE_STEAL_EN
  logic       rel_found;
  logic [1:0] rel_idx, rel_rank;
  logic [1:0] held_idx, held_rank;
  logic [1:0] steal_idx;

  // Victim choice for a full pool: oldest RELEASING voice, otherwise the
  // oldest HELD voice. Ranks are unique, so ">=" against a zero start
  // still picks exactly the maximum.
  always_comb begin
    rel_found = 1'b0;
    rel_idx   = 2'd0;
    rel_rank  = 2'd0;
    held_idx  = 2'd0;
    held_rank = 2'd0;
    for (int v = 0; v < 4; v++) begin
      if ((state_q[v] == V_RELEASING) && (!rel_found || (rank_q[v] > rel_rank))) begin
        rel_found = 1'b1;
        rel_idx   = 2'(v);
        rel_rank  = rank_q[v];
      end
      if ((state_q[v] == V_HELD) && (rank_q[v] >= held_rank)) begin
        held_idx  = 2'(v);
        held_rank = rank_q[v];
      end
    end
    steal_idx = rel_found ? rel_idx : held_idx;
  end
`endif

  // Choose the voice a note_on lands on: retrigger a voice already
  // sounding that note, else the lowest FREE voice, else the full-pool rule.
  always_comb begin
    alloc_en  = 1'b0;
    alloc_idx = 2'd0;
    drop_d    = 1'b0;
    if (ev_on) begin
      if (hit_found) begin
        alloc_en  = 1'b1;
        alloc_idx = hit_idx;
      end else if (free_found) begin
        alloc_en  = 1'b1;
        alloc_idx = free_idx;
      end else begin
`ifdef KP_VOICE_STEAL_EN
        alloc_en  = 1'b1;
        alloc_idx = steal_idx;
`else
        drop_d    = 1'b1;
`endif
      end
    end
    old_rank = rank_q[alloc_idx];
  end

  // Per-voice next state. Priority, lowest to highest: hold, voice_done
  // (returns a sounding voice to FREE), note_off, allocation. A voice that
  // finishes in the same cycle as its note_off just goes FREE without a
  // release pulse.
  always_comb begin
    trig_d = 4'b0000;
    rel_d  = 4'b0000;
    for (int v = 0; v < 4; v++) begin
      state_d[v] = state_q[v];
      rank_d[v]  = rank_q[v];
      note_d[v]  = note_q[v];
      vel_d[v]   = vel_q[v];

      if ((state_q[v] != V_FREE) && bus.voice_done[v])
        state_d[v] = V_FREE;

      if (ev_off && off_found && (off_idx == 2'(v)) && !bus.voice_done[v]) begin
        state_d[v] = V_RELEASING;
        rel_d[v]   = 1'b1;
      end

      // Aging: the allocated voice becomes youngest, every voice younger
      // than its old rank moves one step older, keeping a permutation.
      if (alloc_en) begin
        if (alloc_idx == 2'(v)) begin
          state_d[v] = V_HELD;
          note_d[v]  = bus.note_number;
          vel_d[v]   = bus.velocity;
          rank_d[v]  = 2'd0;
          trig_d[v]  = 1'b1;
        end else if (rank_q[v] < old_rank) begin
          rank_d[v]  = rank_q[v] + 2'd1;
        end
      end
    end
  end

  // State register; reset discards any strobe present in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < 4; v++) begin
        state_q[v] <= V_FREE;
        rank_q[v]  <= 2'(v);
        note_q[v]  <= 7'd0;
        vel_q[v]   <= 7'd0;
      end
      trig_q <= 4'b0000;
      rel_q  <= 4'b0000;
      drop_q <= 1'b0;
    end else begin
      for (int v = 0; v < 4; v++) begin
        state_q[v] <= state_d[v];
        rank_q[v]  <= rank_d[v];
        note_q[v]  <= note_d[v];
        vel_q[v]   <= vel_d[v];
      end
      trig_q <= trig_d;
      rel_q  <= rel_d;
      drop_q <= drop_d;
    end
  end

  // Pack per-voice note/velocity onto the flat output buses.
  always_comb begin
    note_bus = '0;
    vel_bus  = '0;
    for (int v = 0; v < 4; v++) begin
      note_bus[7*v +: 7] = note_q[v];
      vel_bus[7*v +: 7]  = vel_q[v];
    end
  end

  assign bus.trig          = trig_q;
  assign bus.voice_release = rel_q;
  assign bus.note_dropped  = drop_q;
  assign bus.voice_note    = note_bus;
  assign bus.voice_vel     = vel_bus;
  assign bus.voice_active  = {state_q[3] != V_FREE, state_q[2] != V_FREE,
                              state_q[1] != V_FREE, state_q[0] != V_FREE};

endmodule

// File: doc/kp_voice_alloc.md
KP_VOICE_ALLOC -- requirements
Module: kp_voice_alloc

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port note_on, input, 1 bit: one-cycle strobe, note-on event valid.
REQ-004 SHALL have port note_off, input, 1 bit: one-cycle strobe, note-off event valid.
REQ-005 SHALL have port note_number, input, 7 bits: MIDI note, sampled with either strobe.
REQ-006 SHALL have port velocity, input, 7 bits: MIDI velocity, sampled with note_on.
REQ-007 SHALL have port voice_done, input, 4 bits: per-voice level from the string engine, delay line decayed to silence.
REQ-008 SHALL have port trig, output, 4 bits: per-voice one-cycle pulse, start pluck (noise burst load).
REQ-009 SHALL have port release, output, 4 bits: per-voice one-cycle pulse, switch engine to release decay.
REQ-010 SHALL have port voice_note, output, 28 bits: 4x7 packed, voice v at [7v+6:7v].
REQ-011 SHALL have port voice_vel, output, 28 bits: 4x7 packed, same layout.
REQ-012 SHALL have port voice_active, output, 4 bits: voice state not FREE.
REQ-013 SHALL have port note_dropped, output, 1 bit: one-cycle pulse, note_on discarded.

Function
REQ-014 SHALL keep per voice a state in {FREE, HELD, RELEASING}, a 2-bit age rank, and registered note/velocity.
REQ-015 SHALL treat note_on with velocity==0 as note_off for the same note_number.
REQ-016 On note_on: if a HELD/RELEASING voice holds note_number, SHALL retrigger that voice; else SHALL take the lowest-index FREE voice; else SHALL apply REQ-030.
REQ-017 Allocated voice SHALL load note/velocity, enter HELD, and pulse trig exactly 1 cycle after the strobe is sampled.
REQ-018 On note_off: the lowest-index HELD voice matching note_number SHALL enter RELEASING and pulse release 1 cycle later; no match -> no action.
REQ-019 voice_done high in HELD or RELEASING SHALL return that voice to FREE next cycle; voice_done in FREE SHALL be ignored.
REQ-020 note_on and note_off in the same cycle: note_on SHALL be processed, note_off discarded.
REQ-021 Allocation and voice_done on the same voice in the same cycle: allocation SHALL win (voice HELD).
REQ-022 Ages: allocated voice SHALL get rank 0; every voice with rank below its old rank SHALL increment; ranks stay a permutation of 0..3.
REQ-023 At most one trig bit and one release bit SHALL be high per cycle.
REQ-024 voice_note/voice_vel SHALL hold last values when a voice goes FREE.
REQ-025 Throughput: one event per cycle, no backpressure.

Reset
REQ-026 On reset all voices SHALL be FREE, voice_note/voice_vel 0, age rank of voice v = v.
REQ-027 On reset trig, release, voice_active, note_dropped SHALL be 0 the following cycle.
REQ-028 Strobes coinciding with reset SHALL be discarded, including mid-note; no trig/release pulse emitted.

Configuration
REQ-029 Macro KP_VOICE_STEAL_EN SHALL select full-pool behaviour.
REQ-030 With KP_VOICE_STEAL_EN defined, full pool SHALL steal the highest-rank RELEASING voice, else highest-rank HELD voice, trig it per REQ-017, note_dropped stays 0; undefined, note_on SHALL be discarded and note_dropped pulse 1 cycle later.

Verification
REQ-031 Reset, note_on n=60 v=100 -> trig=0001 next cycle, voice_note[6:0]=60, voice_vel[6:0]=100, voice_active=0001.
REQ-032 note_on 60,62,64,67 then note_off 62 -> release=0010 one cycle after the strobe, voice 1 RELEASING, voice_active=1111.
REQ-033 Full pool (60,62,64,67 HELD), note_on 72: with macro -> trig=0001, voice_note[6:0]=72; without -> note_dropped=1, trig=0000.
REQ-034 note_on 60 v=0 while voice 0 holds 60 -> release=0001, no trig.
REQ-035 Voice 0 RELEASING, voice_done=0001 -> voice_active=0000 next cycle; following note_on 65 reuses voice 0.
REQ-036 note_on 60 and note_off 60 same cycle, then reset asserted during HELD -> trig=0001 then all outputs 0, voice_active=0000.
